// File: rtl/sp_ram_be.sv
// sp_ram_be: single-port synchronous RAM with per-byte write enables,
// selectable read-during-write behaviour, optional output register and a
// clear sequencer that zeroes every word after each reset.

// One byte lane of storage: DEPTH x 8 bits, synchronous write, asynchronous
// read that the top level captures into its output register.
module sp_ram_be_lane #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  // Byte write; contents are not reset, the clear sequencer zeroes them.
  always_ff @(posedge clk) begin
    if (wr) mem[addr] <= wdata;
  end

  // Pre-write contents; the top level merges and registers this.
  assign rdata = mem[addr];

endmodule

module sp_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int WRITE_MODE = 0,  // 0 read-first, 1 write-first, 2 no-change
  parameter int OUT_REG    = 0   // 1 adds a second output register
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    init_busy
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int STAGES = (OUT_REG != 0) ? 1 : 0;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
  } req_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_wr;

  req_t                    req;
  logic                    acc;
  logic                    wr_hit;

  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [NB-1:0]           lane_wr;
  logic [NB-1:0][7:0]      lane_wdata;
  logic [NB-1:0][7:0]      lane_rdata;
  logic [NB-1:0][7:0]      merged;

  logic                    rd_vld;
  logic [DATA_WIDTH-1:0]   rd_dat;
  logic [STAGES:0]                  vld_pipe;
  logic [STAGES:0][DATA_WIDTH-1:0]  dat_pipe;

  assign req.en   = en;
  assign req.we   = we;
  assign req.be   = be;
  assign req.addr = addr;
  assign req.din  = din;

  // FSM state and clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: INIT zeroes one word per clock and exits after the last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_wr = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_wr = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
      end
      default: ;
    endcase
  end

  assign init_busy = (state_q == ST_INIT);

  // Only READY accepts accesses; a write with no byte enabled acts as a read.
  assign acc    = (state_q == ST_READY) && req.en;
  assign wr_hit = acc && req.we && (|req.be);

  // Lane controls: the sequencer owns the array while clearing.
  always_comb begin
    mem_addr = init_wr ? cnt_q : req.addr;
    for (int i = 0; i < NB; i++) begin
      lane_wr[i]    = init_wr | (wr_hit & req.be[i]);
      lane_wdata[i] = init_wr ? 8'h00 : req.din[8*i +: 8];
      merged[i]     = req.be[i] ? req.din[8*i +: 8] : lane_rdata[i];
    end
  end

  sp_ram_be_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane [NB-1:0] (
    .clk   (clk),
    .wr    (lane_wr),
    .addr  (mem_addr),
    .wdata (lane_wdata),
    .rdata (lane_rdata)
  );

  // Read-data selection by read-during-write mode.
  always_comb begin
    rd_vld = 1'b0;
    rd_dat = lane_rdata;
    if (acc) begin
      if (!wr_hit) begin
        rd_vld = 1'b1;
      end else if (WRITE_MODE == 1) begin
        rd_vld = 1'b1;
        rd_dat = merged;
      end else if (WRITE_MODE != 2) begin
        rd_vld = 1'b1;
      end
    end
  end

  // Output pipeline: data only advances with its valid, so dout holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_vld;
      if (rd_vld) dat_pipe[0] <= rd_dat;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign dout       = dat_pipe[STAGES];
  assign dout_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_sp_ram_be.sv
// tb_sp_ram_be: four instances (read-first, write-first, no-change, and
// read-first with output register) share one stimulus stream; a reference
// memory produces expected read results, queued per instance with due cycle.
module tb_sp_ram_be;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NB = 4;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          we = 1'b0;
  logic [NB-1:0] be = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout [ND];
  logic          vld  [ND];
  logic          busy [ND];

  typedef struct { int due; logic [DW-1:0] d; } exp_t;
  exp_t          sq [ND][$];
  logic [DW-1:0] m [16];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  bit            ready = 0;

  sp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(0), .OUT_REG(0)) u_rf (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout[0]), .dout_valid(vld[0]), .init_busy(busy[0]));
  sp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(1), .OUT_REG(0)) u_wf (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout[1]), .dout_valid(vld[1]), .init_busy(busy[1]));
  sp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(2), .OUT_REG(0)) u_nc (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout[2]), .dout_valid(vld[2]), .init_busy(busy[2]));
  sp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(0), .OUT_REG(1)) u_pl (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout[3]), .dout_valid(vld[3]), .init_busy(busy[3]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  // Scoreboard: every dout_valid pops one expectation; late ones are flagged.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      for (int d = 0; d < ND; d++) begin
        if (vld[d]) begin
          total++;
          if (sq[d].size() == 0) begin
            bad++;
            $display("FAIL sb_spurious dut%0d: valid with %h at cyc %0d, none expected", d, dout[d], cyc);
          end else begin
            e = sq[d].pop_front();
            if (e.due != cyc || dout[d] !== e.d) begin
              bad++;
              $display("FAIL sb_data dut%0d: got %h at cyc %0d, want %h at cyc %0d", d, dout[d], cyc, e.d, e.due);
            end
          end
        end else if (sq[d].size() != 0 && sq[d][0].due <= cyc) begin
          total++; bad++;
          $display("FAIL sb_missing dut%0d: no valid at cyc %0d, want %h", d, cyc, sq[d][0].d);
          void'(sq[d].pop_front());
        end
      end
    end
  end

  // One access per call: inputs set after a negedge, edge taken, returns at next negedge.
  task automatic drive(input logic e_, input logic w_, input logic [NB-1:0] b_,
                       input logic [AW-1:0] a_, input logic [DW-1:0] d_);
    logic [DW-1:0] old, mrg;
    exp_t x;
    en = e_; we = w_; be = b_; addr = a_; din = d_;
    if (ready && e_) begin
      old = m[a_];
      for (int i = 0; i < NB; i++) mrg[8*i +: 8] = b_[i] ? d_[8*i +: 8] : old[8*i +: 8];
      for (int d = 0; d < ND; d++) begin
        x.due = cyc + lat(d);
        if (!(w_ && |b_)) x.d = old;
        else if (d == 1) x.d = mrg;
        else if (d == 2) continue;
        else x.d = old;
        sq[d].push_back(x);
      end
      if (w_) m[a_] = mrg;
    end
    @(negedge clk);
  endtask

  task automatic enter_reset();
    rst_n = 1'b0; en = 1'b0; we = 1'b0; ready = 0;
    for (int d = 0; d < ND; d++) sq[d].delete();
    for (int k = 0; k < 16; k++) m[k] = '0;
  endtask

  task automatic test_reset();
    enter_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      total++;
      if (dout[d] !== '0 || vld[d] !== 1'b0 || busy[d] !== 1'b1) begin
        bad++;
        $display("FAIL reset_state dut%0d: dout=%h valid=%b busy=%b, want 0/0/1", d, dout[d], vld[d], busy[d]);
      end
    end
  endtask

  task automatic test_init();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      drive(0, 0, '0, '0, '0);
      for (int d = 0; d < ND; d++) begin
        total++;
        if (busy[d] !== (k < 16)) begin
          bad++;
          $display("FAIL init_busy dut%0d: edge %0d busy=%b, want %b", d, k, busy[d], k < 16);
        end
      end
    end
    ready = 1;
    for (int k = 0; k < 16; k++) drive(1, 0, '0, AW'(k), '0);
    drive(0, 0, '0, '0, '0);
  endtask

  task automatic test_byte_enable();
    drive(1, 1, 4'b1111, 4'd3, 32'hAABBCCDD);
    drive(1, 1, 4'b0010, 4'd3, 32'h11223344);
    drive(1, 0, 4'b0000, 4'd3, '0);
    total++;
    if (dout[0] !== 32'hAABB33DD || vld[0] !== 1'b1) begin
      bad++;
      $display("FAIL byte_merge: dout=%h valid=%b, want aabb33dd/1", dout[0], vld[0]);
    end
    // no byte enabled: a read in every mode, memory untouched
    drive(1, 1, 4'b0000, 4'd3, 32'hFFFFFFFF);
    total++;
    if (dout[2] !== 32'hAABB33DD || vld[2] !== 1'b1) begin
      bad++;
      $display("FAIL be_zero_nc: dout=%h valid=%b, want aabb33dd/1", dout[2], vld[2]);
    end
    drive(1, 0, '0, 4'd3, '0);
    drive(0, 0, '0, '0, '0);
  endtask

  task automatic test_rdw();
    drive(1, 1, 4'hF, 4'd2, 32'hAABBCCDD);
    drive(1, 0, 4'h0, 4'd2, '0);
    drive(1, 1, 4'hF, 4'd2, 32'h00000005);
    total++;
    if (dout[0] !== 32'hAABBCCDD || vld[0] !== 1'b1) begin
      bad++; $display("FAIL rdw_read_first: dout=%h valid=%b, want aabbccdd/1", dout[0], vld[0]);
    end
    total++;
    if (dout[1] !== 32'h00000005 || vld[1] !== 1'b1) begin
      bad++; $display("FAIL rdw_write_first: dout=%h valid=%b, want 00000005/1", dout[1], vld[1]);
    end
    total++;
    if (dout[2] !== 32'hAABBCCDD || vld[2] !== 1'b0) begin
      bad++; $display("FAIL rdw_no_change: dout=%h valid=%b, want aabbccdd/0", dout[2], vld[2]);
    end
    drive(1, 0, 4'h0, 4'd2, '0);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (dout[d] !== 32'h00000005) begin
        bad++; $display("FAIL rdw_readback dut%0d: dout=%h, want 00000005", d, dout[d]);
      end
    end
    drive(0, 0, '0, '0, '0);
  endtask

  task automatic test_pipeline();
    int nv;
    for (int k = 0; k < 8; k++) drive(1, 1, 4'hF, AW'(k), DW'(k * 32'h11));
    repeat (2) drive(0, 0, '0, '0, '0);
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, '0, AW'(k), '0);
      nv += int'(vld[3]);
    end
    repeat (3) begin
      drive(0, 0, '0, '0, '0);
      nv += int'(vld[3]);
    end
    total++;
    if (nv != 8) begin
      bad++; $display("FAIL pipe_valid_count: %0d valid cycles, want 8", nv);
    end
    total++;
    if (dout[3] !== 32'h77 || vld[3] !== 1'b0) begin
      bad++; $display("FAIL pipe_hold: dout=%h valid=%b, want 00000077/0", dout[3], vld[3]);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a;
    drive(1, 1, 4'hF, 4'd0, 32'h0BADF00D);
    drive(1, 1, 4'hF, 4'd15, 32'hCAFEF00D);
    a = 4'hF;
    a = a + 1'b1;
    drive(1, 0, '0, a, '0);
    total++;
    if (dout[0] !== 32'h0BADF00D) begin
      bad++; $display("FAIL addr_wrap: dout=%h, want 0badf00d", dout[0]);
    end
    drive(0, 0, '0, '0, '0);
  endtask

  task automatic test_ignored();
    enter_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) drive(1, 1, 4'hF, 4'd5, 32'hDEADBEEF);
    ready = 1;
    drive(1, 1, 4'hF, 4'd4, 32'h00000012);
    drive(1, 0, '0, 4'd5, '0);
    total++;
    if (dout[0] !== 32'h0 || vld[0] !== 1'b1) begin
      bad++; $display("FAIL init_ignored: dout=%h valid=%b, want 00000000/1", dout[0], vld[0]);
    end
    drive(0, 0, '0, '0, '0);
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 4'hF, 4'd3, 32'h12345678);
    drive(1, 0, '0, 4'd3, '0);
    drive(1, 0, '0, 4'd3, '0);
    #2;
    enter_reset();
    #1;
    for (int d = 0; d < ND; d++) begin
      total++;
      if (dout[d] !== '0 || vld[d] !== 1'b0) begin
        bad++; $display("FAIL mid_reset dut%0d: dout=%h valid=%b, want 0/0", d, dout[d], vld[d]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      drive(0, 0, '0, '0, '0);
      total++;
      if (busy[3] !== (k < 16)) begin
        bad++; $display("FAIL mid_reset_busy: edge %0d busy=%b, want %b", k, busy[3], k < 16);
      end
    end
    ready = 1;
    drive(1, 0, '0, 4'd3, '0);
    repeat (2) drive(0, 0, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_init();
    test_byte_enable();
    test_rdw();
    test_pipeline();
    test_wrap();
    test_ignored();
    test_reset_mid();
    repeat (3) drive(0, 0, '0, '0, '0);
    for (int d = 0; d < ND; d++) begin
      total++;
      if (sq[d].size() != 0) begin
        bad++; $display("FAIL sb_leftover dut%0d: %0d expected reads never seen", d, sq[d].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sp_ram_be.md
# sp_ram_be

Parametrised single-port synchronous RAM with per-byte write enables, selectable read-during-write behaviour, an optional output pipeline register and a self-clearing initialisation sequencer. It is the next-generation storage primitive for the FIFO and buffer blocks in this directory, replacing the plain single-port RAM wherever deterministic power-up contents, partial-word writes or a registered read path are needed.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 4: address width; DEPTH = 2**ADDR_WIDTH words.
- WRITE_MODE, 0: read-during-write behaviour; 0 = read-first, 1 = write-first, 2 = no-change.
- OUT_REG, 0: 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all sampling on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  access request, sampled at posedge.
- we  in  1  write qualifier; meaningful only when en=1.
- be  in  DATA_WIDTH/8  byte enables; be[i] covers din[8i+7:8i].
- addr  in  ADDR_WIDTH  word address.
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  one-cycle pulse marking new data on dout.
- init_busy  out  1  high while the clear sequencer runs; accesses are ignored.

## Operation
- FSM with two states: INIT and READY. Reset enters INIT with clear counter = 0.
- INIT: each clock writes 0 to mem[counter] and increments counter. When counter = DEPTH-1 is written, go to READY. en/we/be/addr/din are ignored; no dout_valid.
- READY, en=0: no memory change; dout holds; dout_valid=0.
- READY, en=1, we=0: read mem[addr]; dout_valid pulses with the data.
- READY, en=1, we=1: for every i with be[i]=1, byte i of mem[addr] is replaced with din byte i. Other bytes are unchanged. dout depends on WRITE_MODE:
  - read-first: old word, with dout_valid.
  - write-first: merged new word, with dout_valid.
  - no-change: dout holds and dout_valid=0.
- we=1 with be all zero: no memory change; treated as a read for dout and dout_valid in all modes.
- Address wraps naturally; no range checks. Writing DEPTH-1 then incrementing addresses word 0.
- Reset mid-operation:
  - dout, dout_valid and any pipeline stage clear immediately.
  - The FSM returns to INIT and the full clear reruns, so all prior contents are lost.

## Timing
- During reset: dout=0, dout_valid=0, init_busy=1, FSM=INIT, counter=0, output pipeline register=0.
- init_busy stays high for exactly DEPTH rising edges after rst_n deasserts. It falls on the edge that clears word DEPTH-1.
- The first access accepted is at edge DEPTH+1 after reset release.
- Latency is measured from the sampling edge E of an accepted access. dout and dout_valid update at:
  - E (visible after E) when OUT_REG=0;
  - E+1 when OUT_REG=1.
- Full throughput: one access per cycle, back-to-back reads and writes, no stalls.
- dout_valid is high exactly one cycle per qualifying access.
- A read at E+1 of the address written at E returns the merged data, in every mode.

## Test plan
- Init: release rst_n with DATA_WIDTH=32, ADDR_WIDTH=4 -> init_busy high for exactly 16 cycles. Reads of addresses 0..15 then return 0x00000000.
- Byte enables:
  - Write 0xAABBCCDD to addr 3 with be=4'b1111.
  - Then write 0x11223344 to addr 3 with be=4'b0010.
  - Read addr 3 -> 0xAABB33DD with dout_valid.
- Read-during-write: addr 2 holds 0xAABBCCDD; write 0x00000005 with be=4'hF.
  - WRITE_MODE=0 -> dout=0xAABBCCDD, valid=1.
  - WRITE_MODE=1 -> dout=0x00000005, valid=1.
  - WRITE_MODE=2 -> dout unchanged, valid=0.
  - Subsequent read of addr 2 -> 0x00000005 in all three modes.
- Pipeline: OUT_REG=1; mem[k]=k*0x11; back-to-back reads of addr 0..7 on consecutive cycles -> dout=0x00,0x11,...,0x77 on consecutive cycles starting 2 cycles after the first request, with dout_valid high for 8 cycles. en=0 afterwards -> dout holds 0x77, valid=0.
- Ignored and wrapping accesses:
  - Write 0xDEADBEEF to addr 5 while init_busy=1 -> after init, addr 5 reads 0.
  - Write addr 15, then increment addr -> next read hits word 0.
- Reset mid-operation: assert rst_n low while a read is in the OUT_REG=1 pipeline -> dout=0 and valid=0 immediately. After release, init_busy is high for 16 cycles and previously written addr 3 reads 0.
